// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - Opcodes, state type and control encodings shared by mc_ctrl_fsm.
// States BNEEX/LOGIEX are only reachable when MC_CTRL_EXT_OPS_EN is defined.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef logic [2:0] aluop_t;
   localparam aluop_t ALU_ADD   = 3'b000;
   localparam aluop_t ALU_SUB   = 3'b001;
   localparam aluop_t ALU_FUNCT = 3'b010;
   localparam aluop_t ALU_AND   = 3'b011;
   localparam aluop_t ALU_OR    = 3'b100;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
      BEQEX, ADDIEX, ADDIWB, JEX, BNEEX, LOGIEX
   } mc_state_t;

   typedef struct packed {
      logic       memwrite;
      logic       regwrite;
      logic       iord;
      logic       memtoreg;
      logic       regdst;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      aluop_t     aluop;
      logic       zeroext;
      logic       retire;
   } mc_ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// rtl/mc_ctrl_outdec.sv - Combinational state-to-control-word decoder (Moore part of the outputs).
// MC_CTRL_EXT_OPS_EN adds decode for BNEEX and LOGIEX.
module mc_ctrl_outdec
   import mc_ctrl_pkg::*;
(
   input  mc_state_t state,
   output mc_ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         FETCH:   ctrl.alusrcb = SRCB_FOUR;
         DECODE:  ctrl.alusrcb = SRCB_IMM_SH2;
         MEMADR: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
         end
         MEMRD:   ctrl.iord = 1'b1;
         MEMWB: begin
            ctrl.regwrite = 1'b1;
            ctrl.memtoreg = 1'b1;
            ctrl.retire   = 1'b1;
         end
         MEMWR: begin
            ctrl.iord     = 1'b1;
            ctrl.memwrite = 1'b1;
         end
         RTYPEEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_B;
            ctrl.aluop   = ALU_FUNCT;
         end
         RTYPEWB: begin
            ctrl.regwrite = 1'b1;
            ctrl.regdst   = 1'b1;
            ctrl.retire   = 1'b1;
         end
         BEQEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_B;
            ctrl.aluop   = ALU_SUB;
            ctrl.pcsrc   = PCSRC_ALUOUT;
            ctrl.retire  = 1'b1;
         end
         ADDIEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
         end
         ADDIWB: begin
            ctrl.regwrite = 1'b1;
            ctrl.retire   = 1'b1;
         end
         JEX: begin
            ctrl.pcsrc  = PCSRC_JUMP;
            ctrl.retire = 1'b1;
         end
`ifdef MC_CTRL_EXT_OPS_EN
         BNEEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_B;
            ctrl.aluop   = ALU_SUB;
            ctrl.pcsrc   = PCSRC_ALUOUT;
            ctrl.retire  = 1'b1;
         end
         LOGIEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
            ctrl.aluop   = ALU_AND;
            ctrl.zeroext = 1'b1;
         end
`endif
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - Multicycle MIPS control FSM: state register, next-state and enable qualification.
// MC_CTRL_EXT_OPS_EN adds bne/andi/ori; undefined, those opcodes decode as illegal.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int RESET_STATE_FETCH = 1
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcen,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] aluop,
   output logic       zeroext,
   output logic       illegal,
   output logic       retire
);

   if (RESET_STATE_FETCH != 1) begin : g_param_check
      $error("mc_ctrl_fsm: RESET_STATE_FETCH must be 1");
   end

   mc_state_t state_q, state_d;
   mc_ctrl_t  dec;
   logic      op_bad;
   logic      fetch_go;
   logic      branch_taken;

   mc_ctrl_outdec u_outdec (
      .state (state_q),
      .ctrl  (dec)
   );

   always_comb begin
      state_d = state_q;
      op_bad  = 1'b0;
      case (state_q)
         FETCH:   if (mem_ready) state_d = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = RTYPEEX;
               OP_BEQ:       state_d = BEQEX;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JEX;
`ifdef MC_CTRL_EXT_OPS_EN
               OP_BNE:          state_d = BNEEX;
               OP_ANDI, OP_ORI: state_d = LOGIEX;
`endif
               default: begin
                  state_d = FETCH;
                  op_bad  = 1'b1;
               end
            endcase
         end
         MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   if (mem_ready) state_d = MEMWB;
         MEMWR:   if (mem_ready) state_d = FETCH;
         RTYPEEX: state_d = RTYPEWB;
         ADDIEX:  state_d = ADDIWB;
         LOGIEX:  state_d = ADDIWB;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= FETCH;
      else        state_q <= state_d;
   end

   // Write enables and pulses are gated by reset directly so nothing fires while it is held.
   always_comb begin
      fetch_go     = (state_q == FETCH) && mem_ready;
      branch_taken = (state_q == BEQEX) && zero;
`ifdef MC_CTRL_EXT_OPS_EN
      branch_taken = branch_taken || ((state_q == BNEEX) && !zero);
`endif
      pcen     = reset && (fetch_go || (state_q == JEX) || branch_taken);
      irwrite  = reset && fetch_go;
      memwrite = reset && dec.memwrite;
      regwrite = reset && dec.regwrite;
      retire   = reset && (dec.retire || ((state_q == MEMWR) && mem_ready));
      illegal  = reset && op_bad;
      iord     = dec.iord;
      memtoreg = dec.memtoreg;
      regdst   = dec.regdst;
      alusrca  = dec.alusrca;
      alusrcb  = dec.alusrcb;
      pcsrc    = dec.pcsrc;
      aluop    = dec.aluop;
      zeroext  = dec.zeroext;
`ifdef MC_CTRL_EXT_OPS_EN
      // IR is stable for the whole instruction, so op picks and/or and keeps zeroext through ADDIWB.
      if ((state_q == LOGIEX) && (op == OP_ORI)) aluop = ALU_OR;
      if ((state_q == ADDIWB) && ((op == OP_ANDI) || (op == OP_ORI))) zeroext = 1'b1;
`endif
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - Self-checking bench for mc_ctrl_fsm against a per-instruction cycle-plan model.
// Honours MC_CTRL_EXT_OPS_EN the same way as the design.
module tb_mc_ctrl_fsm;

   localparam logic [5:0] C_R    = 6'b000000;
   localparam logic [5:0] C_J    = 6'b000010;
   localparam logic [5:0] C_BEQ  = 6'b000100;
   localparam logic [5:0] C_BNE  = 6'b000101;
   localparam logic [5:0] C_ADDI = 6'b001000;
   localparam logic [5:0] C_ANDI = 6'b001100;
   localparam logic [5:0] C_ORI  = 6'b001101;
   localparam logic [5:0] C_LW   = 6'b100011;
   localparam logic [5:0] C_SW   = 6'b101011;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] op = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] aluop;
   logic       zeroext, illegal, retire;

   always #5 clk = ~clk;

   mc_ctrl_fsm dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
      .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
      .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .zeroext(zeroext),
      .illegal(illegal), .retire(retire)
   );

   typedef struct packed {
      logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
      logic [1:0] alusrcb, pcsrc;
      logic [2:0] aluop;
      logic       zeroext, illegal, retire;
   } ctl_t;

   ctl_t obs;
   assign obs = {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                 alusrcb, pcsrc, aluop, zeroext, illegal, retire};

   int n_checks = 0;
   int n_fails  = 0;
   string cur_tag = "init";

   ctl_t       exp_q[$], care_q[$];
   logic       rdy_q[$], z_q[$];
   logic [5:0] op_q[$];
   ctl_t       cv, cc;
   logic [5:0] plan_op;
   logic       plan_z;
   int lat, n_mw, n_ret, n_ill, n_rw;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_checks++;
      assert (o === e) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   function automatic logic is_legal(input logic [5:0] o);
      logic ok;
      ok = (o == C_R) || (o == C_J) || (o == C_BEQ) || (o == C_ADDI) || (o == C_LW) || (o == C_SW);
`ifdef MC_CTRL_EXT_OPS_EN
      ok = ok || (o == C_BNE) || (o == C_ANDI) || (o == C_ORI);
`endif
      return ok;
   endfunction

   // Every cycle specifies all enables, pulses and zeroext; selects only where the instruction cares.
   function automatic void start_cycle();
      cv = '0;
      cc = '0;
      cc.pcen = 1'b1; cc.memwrite = 1'b1; cc.irwrite = 1'b1; cc.regwrite = 1'b1;
      cc.zeroext = 1'b1; cc.illegal = 1'b1; cc.retire = 1'b1;
   endfunction

   function automatic void want_a(input logic v);       cv.alusrca = v; cc.alusrca = 1'b1; endfunction
   function automatic void want_b(input logic [1:0] v); cv.alusrcb = v; cc.alusrcb = 2'b11; endfunction
   function automatic void want_alu(input logic [2:0] v); cv.aluop = v; cc.aluop = 3'b111; endfunction
   function automatic void want_pc(input logic [1:0] v); cv.pcsrc = v; cc.pcsrc = 2'b11; endfunction
   function automatic void want_iord(input logic v);    cv.iord = v; cc.iord = 1'b1; endfunction
   function automatic void want_wb(input logic rd, input logic m2r);
      cv.regdst = rd; cc.regdst = 1'b1; cv.memtoreg = m2r; cc.memtoreg = 1'b1;
   endfunction

   function automatic void push(input logic rdy);
      exp_q.push_back(cv); care_q.push_back(cc); rdy_q.push_back(rdy);
      z_q.push_back(plan_z); op_q.push_back(plan_op);
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic void fetch_sel();
      want_iord(1'b0); want_a(1'b0); want_b(2'b01); want_alu(3'b000); want_pc(2'b00);
   endfunction

   task automatic plan_instr(input logic [5:0] o, input logic z, input int fw, input int mw);
      plan_op = o;
      plan_z  = z;
      repeat (fw) begin start_cycle(); fetch_sel(); push(1'b0); end
      start_cycle(); fetch_sel(); cv.pcen = 1'b1; cv.irwrite = 1'b1; push(1'b1);
      start_cycle(); want_a(1'b0); want_b(2'b11); want_alu(3'b000);
      if (!is_legal(o)) begin
         cv.illegal = 1'b1;
         push(rnd());
         return;
      end
      push(rnd());
      if (o == C_LW || o == C_SW) begin
         start_cycle(); want_a(1'b1); want_b(2'b10); want_alu(3'b000); push(rnd());
         if (o == C_LW) begin
            repeat (mw) begin start_cycle(); want_iord(1'b1); push(1'b0); end
            start_cycle(); want_iord(1'b1); push(1'b1);
            start_cycle(); cv.regwrite = 1'b1; cv.retire = 1'b1; want_wb(1'b0, 1'b1); push(rnd());
         end else begin
            repeat (mw) begin start_cycle(); want_iord(1'b1); cv.memwrite = 1'b1; push(1'b0); end
            start_cycle(); want_iord(1'b1); cv.memwrite = 1'b1; cv.retire = 1'b1; push(1'b1);
         end
      end else if (o == C_R) begin
         start_cycle(); want_a(1'b1); want_b(2'b00); want_alu(3'b010); push(rnd());
         start_cycle(); cv.regwrite = 1'b1; cv.retire = 1'b1; want_wb(1'b1, 1'b0); push(rnd());
      end else if (o == C_BEQ || o == C_BNE) begin
         start_cycle(); want_a(1'b1); want_b(2'b00); want_alu(3'b001); want_pc(2'b01);
         cv.pcen = (o == C_BEQ) ? z : !z;
         cv.retire = 1'b1;
         push(rnd());
      end else if (o == C_J) begin
         start_cycle(); want_pc(2'b10); cv.pcen = 1'b1; cv.retire = 1'b1; push(rnd());
      end else begin
         start_cycle(); want_a(1'b1); want_b(2'b10);
         if (o == C_ADDI) want_alu(3'b000);
         else begin
            want_alu((o == C_ORI) ? 3'b100 : 3'b011);
            cv.zeroext = 1'b1;
         end
         push(rnd());
         start_cycle(); cv.regwrite = 1'b1; cv.retire = 1'b1; want_wb(1'b0, 1'b0);
         cv.zeroext = (o != C_ADDI);
         push(rnd());
      end
   endtask

   task automatic run_plan(input int max_cyc);
      ctl_t e, m;
      int cyc;
      cyc = 0; lat = 0; n_mw = 0; n_ret = 0; n_ill = 0; n_rw = 0;
      while (exp_q.size() > 0 && cyc < max_cyc) begin
         e = exp_q.pop_front();
         m = care_q.pop_front();
         @(negedge clk);
         mem_ready = rdy_q.pop_front();
         zero      = z_q.pop_front();
         op        = op_q.pop_front();
         #1;
         cyc++;
         n_checks++;
         assert ((obs & m) === (e & m)) else begin
            n_fails++;
            $error("FAIL %s cycle %0d: observed %h expected %h (care %h)", cur_tag, cyc, obs, e, m);
         end
         if (obs.retire === 1'b1 && lat == 0) lat = cyc;
         if (obs.memwrite === 1'b1) n_mw++;
         if (obs.retire === 1'b1)   n_ret++;
         if (obs.illegal === 1'b1)  n_ill++;
         if (obs.regwrite === 1'b1) n_rw++;
      end
      exp_q.delete(); care_q.delete(); rdy_q.delete(); z_q.delete(); op_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [5:0] ops [9];
      logic [5:0] ro;
      ops = '{C_R, C_J, C_BEQ, C_BNE, C_ADDI, C_ANDI, C_ORI, C_LW, C_SW};

      // Reset held with mem_ready high: no enables, FETCH selects.
      reset = 1'b0; mem_ready = 1'b1; op = C_LW;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_pcen", 32'(pcen), 32'd0);
      chk("rst_irwrite", 32'(irwrite), 32'd0);
      chk("rst_regwrite", 32'(regwrite), 32'd0);
      chk("rst_memwrite", 32'(memwrite), 32'd0);
      chk("rst_iord", 32'(iord), 32'd0);
      chk("rst_alusrcb", 32'(alusrcb), 32'd1);
      chk("rst_alusrca", 32'(alusrca), 32'd0);
      chk("rst_aluop", 32'(aluop), 32'd0);
      chk("rst_pcsrc", 32'(pcsrc), 32'd0);
      chk("rst_pulses", 32'({illegal, retire, zeroext}), 32'd0);
      mem_ready = 1'b0;
      reset = 1'b1;

      // lw aborted by reset in MEMRD.
      cur_tag = "lw_abort";
      plan_instr(C_LW, 1'b0, 0, 6);
      run_plan(4);
      @(negedge clk);
      reset = 1'b0; mem_ready = 1'b1;
      #1;
      chk("abort_regwrite", 32'(regwrite), 32'd0);
      chk("abort_iord", 32'(iord), 32'd0);
      chk("abort_pcen", 32'(pcen), 32'd0);
      @(negedge clk);
      #1;
      chk("abort_hold_regwrite", 32'(regwrite), 32'd0);
      mem_ready = 1'b0;
      reset = 1'b1;
      cur_tag = "after_abort";
      plan_instr(C_R, 1'b0, 1, 0);
      run_plan(100);
      chk("after_abort_regwrite_once", n_rw, 32'd1);

      cur_tag = "lw";
      plan_instr(C_LW, 1'b0, 0, 0);
      run_plan(100);
      chk("lw_latency", lat, 32'd5);
      chk("lw_regwrite", n_rw, 32'd1);

      cur_tag = "sw_wait";
      plan_instr(C_SW, 1'b0, 0, 3);
      run_plan(100);
      chk("sw_memwrite_cycles", n_mw, 32'd4);
      chk("sw_retire_count", n_ret, 32'd1);
      chk("sw_latency", lat, 32'd7);

      cur_tag = "beq_taken";
      plan_instr(C_BEQ, 1'b1, 0, 0);
      run_plan(100);
      chk("beq_taken_latency", lat, 32'd3);
      cur_tag = "beq_not_taken";
      plan_instr(C_BEQ, 1'b0, 0, 0);
      run_plan(100);
      chk("beq_nt_latency", lat, 32'd3);

      cur_tag = "r_type";
      plan_instr(C_R, 1'b0, 0, 0);
      run_plan(100);
      chk("r_latency", lat, 32'd4);
      cur_tag = "addi";
      plan_instr(C_ADDI, 1'b0, 0, 0);
      run_plan(100);
      chk("addi_latency", lat, 32'd4);
      cur_tag = "j_long_fetch_stall";
      plan_instr(C_J, 1'b0, 30, 0);
      run_plan(100);
      chk("j_stall_latency", lat, 32'd33);

      cur_tag = "illegal_111111";
      plan_instr(6'b111111, 1'b0, 0, 0);
      run_plan(100);
      chk("illegal_pulses", n_ill, 32'd1);
      chk("illegal_no_regwrite", n_rw + n_mw + n_ret, 32'd0);

      cur_tag = "ori";
      plan_instr(C_ORI, 1'b0, 0, 0);
      run_plan(100);
`ifdef MC_CTRL_EXT_OPS_EN
      chk("ori_latency", lat, 32'd4);
      chk("ori_regwrite", n_rw, 32'd1);
`else
      chk("ori_illegal", n_ill, 32'd1);
`endif

      cur_tag = "random";
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 5) == 0) ro = 6'($urandom_range(0, 63));
         else ro = ops[$urandom_range(0, 8)];
         plan_instr(ro, rnd(), $urandom_range(0, 3), $urandom_range(0, 3));
      end
      run_plan(100_000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle control unit that sequences the single-ALU, unified-memory MIPS datapath.
- Decodes the IR opcode and drives register, ALU, PC and memory enables one state per cycle.
- Stalls on a memory-ready handshake so memory with wait states can be shared between instruction fetch and data access.
- Sits inside the core beside the datapath. The memory-select output (iord) and the IR-write output (irwrite) go to the unified memory.

Parameters:
- RESET_STATE_FETCH, 1: reserved; must stay 1. Reset always enters FETCH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- op  in  6  opcode field of the IR (instr[31:26]).
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access this cycle.
- pcen  out  1  PC write enable, with branch resolution applied.
- memwrite  out  1  data memory write strobe.
- irwrite  out  1  instruction register load.
- regwrite  out  1  register file write.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memtoreg  out  1  register writeback select: 1 = memory data.
- regdst  out  1  destination register select: 1 = rd, 0 = rt.
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2.
- pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- aluop  out  3  000 add, 001 sub, 010 use funct, 011 and, 100 or.
- zeroext  out  1  immediate is zero-extended.
- illegal  out  1  one-cycle pulse on an undecodable opcode.
- retire  out  1  one-cycle pulse in the final state of each instruction.

Behaviour:
- Outputs are Moore, decoded from the state register.
  - The exception is pcen and irwrite in FETCH, which are qualified by mem_ready.
- While reset=0: state goes to FETCH immediately.
  - All write enables are forced 0: pcen, memwrite, irwrite, regwrite.
  - illegal and retire are 0.
  - Select outputs take their FETCH values: iord 0, alusrca 0, alusrcb 01, aluop 000, pcsrc 00.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- States and transitions (each arrow is one clock edge):
  - FETCH:
    - Drives iord 0, alusrca 0, alusrcb 01, aluop add, pcsrc 00.
    - irwrite = pcen = mem_ready.
    - Stays in FETCH while mem_ready = 0; moves to DECODE when mem_ready = 1.
  - DECODE:
    - Drives alusrca 0, alusrcb 11, aluop add (branch target computed into ALUOut).
    - Next state: lw/sw -> MEMADR; R -> RTYPEEX; beq -> BEQEX; addi -> ADDIEX; j -> JEX.
    - Any other opcode -> FETCH with illegal = 1.
  - MEMADR: alusrca 1, alusrcb 10, aluop add. lw -> MEMRD; sw -> MEMWR.
  - MEMRD: iord 1. Holds until mem_ready, then -> MEMWB.
  - MEMWB: regwrite 1, memtoreg 1, regdst 0, retire 1 -> FETCH.
  - MEMWR: iord 1, memwrite 1 every cycle until mem_ready. retire 1 in the mem_ready cycle, then -> FETCH.
  - RTYPEEX: alusrca 1, alusrcb 00, aluop funct -> RTYPEWB.
  - RTYPEWB: regwrite 1, regdst 1, memtoreg 0, retire 1 -> FETCH.
  - BEQEX: alusrca 1, alusrcb 00, aluop sub, pcsrc 01, pcen = zero, retire 1 -> FETCH.
  - ADDIEX: alusrca 1, alusrcb 10, aluop add -> ADDIWB.
  - ADDIWB: regwrite 1, regdst 0, memtoreg 0, retire 1 -> FETCH.
  - JEX: pcsrc 10, pcen 1, retire 1 -> FETCH.
- Latency in cycles with no wait states: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
  - Each cycle of mem_ready = 0 adds one cycle in FETCH, MEMRD or MEMWR.
- Boundary conditions:
  - mem_ready held 0 indefinitely: the FSM waits with no timeout.
  - Reset asserted mid-instruction aborts it. There is no partial write after reset deasserts, and the FSM restarts in FETCH.
  - zeroext = 0 in every state unless the optional feature is enabled.

Optional Feature:
- Macro: MC_CTRL_EXT_OPS_EN.
- Defined: adds three opcodes.
  - bne 000101 -> BNEEX: as BEQEX but pcen = ~zero.
  - andi 001100 -> LOGIEX: alusrca 1, alusrcb 10, zeroext 1, aluop and.
  - ori 001101 -> LOGIEX: same as andi but aluop or.
  - LOGIEX -> ADDIWB, with zeroext held 1 there.
- Undefined: bne, andi and ori decode as illegal. aluop codes 011 and 100 are never produced.

Decomposition:
- Shared package:
  - Opcode constants (OP_RTYPE, OP_LW, ...).
  - Enumerated state type mc_state_t.
  - aluop_t constants (ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_AND, ALU_OR).
  - alusrcb and pcsrc encodings.
- One sub-module, mc_ctrl_outdec: purely combinational state-to-control-word decoder.
- The top level holds the state register, next-state logic and the pcen/irwrite qualification.

Test Plan:
- Reset low mid-MEMRD, then high -> state FETCH, regwrite never pulses, first fetch cycle shows iord 0 and alusrcb 01.
- lw (op 100011) with mem_ready always 1 -> retire at cycle 5, MEMWB shows regwrite 1, memtoreg 1, regdst 0.
- sw with mem_ready low for 3 cycles in MEMWR -> memwrite 1 for 4 cycles, single retire, then FETCH.
- beq with zero = 1, then zero = 0 -> pcen 1 and pcsrc 01 in BEQEX for the first; pcen 0 for the second; both take 3 cycles.
- op 111111 -> illegal pulses once in DECODE, next state FETCH, no write enables asserted.
- With MC_CTRL_EXT_OPS_EN: ori (001101) -> LOGIEX shows aluop 100, zeroext 1, then ADDIWB with regwrite 1. Without the macro: same opcode -> illegal.
